i2c_master_byte_ctrl: RTL
=========================

// Module: i2c_master_byte_ctrl
// PURPOSE
//  Byte-level I2C master engine: the initiator-side counterpart of the i2c slave.
//  Executes one command at a time (START, STOP, WRITE byte, READ byte) and drives SCL/SDA as open-drain enables.
//  Supports slave clock stretching and arbitration-loss detection.
//  Sits between the APB i2c register block (command source) and the pad wrapper.
// PARAMETERS
//  QTR       4  clk cycles per quarter-bit phase; legal range 2..2**CNT_BITS-1
//  CNT_BITS  8  width of the internal phase-cycle counter
// PORTS
//  clk        in   1  system clock, all logic on posedge
//  n_rst      in   1  asynchronous active-low reset
//  cmd_valid  in   1  command request
//  cmd_ready  out  1  engine idle, command accepted when cmd_valid & cmd_ready
//  cmd        in   2  00 START, 01 STOP, 10 WRITE, 11 READ; sampled on accept
//  tx_data    in   8  byte for WRITE; sampled on accept
//  send_ack   in   1  READ only: 1 = drive ACK (SDA low) on 9th bit, 0 = NACK; sampled on accept
//  rx_data    out  8  byte received by last READ; holds until next READ completes
//  rx_ack     out  1  SDA sampled on 9th bit of last WRITE (0 = slave ACK)
//  done       out  1  one-cycle pulse at command completion (also on arbitration loss)
//  arb_lost   out  1  one-cycle pulse coincident with done when arbitration is lost
//  scl_in     in   1  SCL line level, already synchronized by the pad wrapper
//  sda_in     in   1  SDA line level, already synchronized by the pad wrapper
//  scl_oe     out  1  1 = pull SCL low, 0 = release
//  sda_oe     out  1  1 = pull SDA low, 0 = release
// BEHAVIOUR
//  Reset: scl_oe=0, sda_oe=0, cmd_ready=1, done=0, arb_lost=0, rx_data=0, rx_ack=0, FSM=IDLE.
//  Async reset mid-command: both lines are released immediately and the command is dropped with no done.
//  FSM states: IDLE, START, STOP, BIT (shared by WRITE/READ, with a 4-bit bit index 0..8), DONE.
//  Accept moves the FSM out of IDLE on the next edge. cmd_ready=0 from then until the cycle after done.
//  Each command runs 4 phases per bit (P0..P3). Each phase lasts QTR cycles, timed by a phase counter 0..QTR-1.
//  Stretch: in P1 the counter holds at 0 while scl_in==0 and counts once scl_in==1.
//  START: P0 SCL and SDA released (stretch rule applies); P1 both released; P2 sda_oe=1; P3 scl_oe=1, sda_oe=1.
//  STOP: P0 scl_oe=1, sda_oe=1; P1 SCL released, SDA low (stretch rule applies); P2 hold; P3 sda_oe=0.
//  Data bit: P0 scl_oe=1, SDA set; P1 SCL released (stretch rule applies); P2 SCL released; P3 scl_oe=1.
//    SDA is set as follows. WRITE: sda_oe=~tx_bit. READ: sda_oe=0 on bits 0..7, sda_oe=send_ack on bit 8.
//  Sampling: sda_in is sampled on the last cycle of P2. Bits are MSB first. Bit 8 is the ACK slot.
//    WRITE: bit 8 releases SDA; rx_ack <= sample.
//    READ: bits 0..7 shift into rx_data; rx_data updates only when done fires.
//  Latency with no stretching: START/STOP done at 4*QTR+1 cycles after accept; WRITE/READ at 36*QTR+1.
//  Stretching adds exactly the stall cycles.
//  Between commands, scl_oe and sda_oe hold their final P3 values. After START/WRITE/READ SCL stays low.
//  Arbitration loss:
//    WRITE bits 0..7: sda_oe=0 but P2 sample==0.
//    START: sda_in==0 during P1.
//    On loss: release both lines next cycle, pulse done and arb_lost, return to IDLE, rx_data/rx_ack unchanged.
//  cmd_valid while busy is ignored; tx_data/send_ack changes while busy have no effect.
// TESTING (QTR=4)
//  START then WRITE 0xA5, slave ACK on bit 8:
//    START done 17 cycles after accept. WRITE done 145 cycles after accept.
//    SDA bit pattern 1,0,1,0,0,1,0,1, then released. rx_ack=0, arb_lost=0.
//  READ with slave driving 0x3C, send_ack=1:
//    rx_data=0x3C at done. sda_oe=1 through bit-8 P0..P3. done 145 cycles after accept.
//  Slave holds scl_in low 20 extra cycles in bit 3 P1 of a WRITE:
//    counter stalls and done arrives at 165 cycles.
//    SCL released and unchanged during stall.
//  WRITE 0xFF, other master forces sda_in=0 at bit 2 P2:
//    done+arb_lost pulse together at that bit, both oe=0 next cycle, cmd_ready=1 after.
//  Reset mid-READ at bit 4, then STOP issued after reset:
//    at reset scl_oe=sda_oe=0 immediately, no done. After reset cmd_ready=1.
//    STOP completes in 17 cycles, ending with sda_oe=0, scl_oe=0.

Source files
------------

// File: rtl/i2c_master_byte_ctrl.sv
// i2c_master_byte_ctrl: byte-level I2C master engine.
// Runs START/STOP/WRITE/READ as four quarter-bit phases per bit.
module i2c_master_byte_ctrl #(
  parameter int QTR      = 4,
  parameter int CNT_BITS = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd,
  input  logic [7:0] tx_data,
  input  logic       send_ack,
  output logic [7:0] rx_data,
  output logic       rx_ack,
  output logic       done,
  output logic       arb_lost,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe
);

  typedef enum logic [2:0] {
    IDLE, START, STOP, BIT, DONE
  } state_t;

  localparam logic [CNT_BITS-1:0] CMAX =
    CNT_BITS'(QTR - 1);

  state_t              state_q, state_d;
  logic [1:0]          ph_q, ph_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic [3:0]          bit_q, bit_d;
  logic                rd_q, rd_d;
  logic                ack_q, ack_d;
  logic [7:0]          tx_q, tx_d;
  logic [7:0]          sh_q, sh_d;
  logic [7:0]          rx_q, rx_d;
  logic                rxack_q, rxack_d;
  logic                done_q, done_d;
  logic                arb_q, arb_d;
  logic                sclh_q, sclh_d;
  logic                sdah_q, sdah_d;
  logic                run, stall, ph_end;
  logic                samp, lost, wbit;

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rd_d    = rd_q;
    ack_d   = ack_q;
    tx_d    = tx_q;
    sh_d    = sh_q;
    rx_d    = rx_q;
    rxack_d = rxack_q;
    done_d  = 1'b0;
    arb_d   = 1'b0;
    sclh_d  = sclh_q;
    sdah_d  = sdah_q;
    scl_oe  = sclh_q;
    sda_oe  = sdah_q;
    lost    = 1'b0;
    run     = (state_q == START) ||
              (state_q == STOP) ||
              (state_q == BIT);
    wbit    = rd_q ? (bit_q == 4'd8 && ack_q)
                   : (bit_q != 4'd8 && !tx_q[7]);
    // SCL is released in these phases; a slave may stretch
    stall   = (ph_q == 2'd1 ||
               (state_q == START && ph_q == 2'd0)) &&
              cnt_q == '0 && !scl_in;
    ph_end  = !stall && cnt_q == CMAX;
    samp    = ph_q == 2'd2 && ph_end;

    unique case (state_q)
      IDLE: begin
        if (cmd_valid && !done_q) begin
          ph_d  = '0;
          cnt_d = '0;
          bit_d = '0;
          tx_d  = tx_data;
          ack_d = send_ack;
          rd_d  = cmd == 2'b11;
          unique case (cmd)
            2'b00:   state_d = START;
            2'b01:   state_d = STOP;
            default: state_d = BIT;
          endcase
        end
      end
      START: begin
        scl_oe = ph_q == 2'd3;
        sda_oe = ph_q[1];
        lost   = ph_q == 2'd1 && !sda_in;
      end
      STOP: begin
        scl_oe = ph_q == 2'd0;
        sda_oe = ph_q != 2'd3;
      end
      BIT: begin
        scl_oe = ph_q == 2'd0 || ph_q == 2'd3;
        sda_oe = wbit;
        if (samp && bit_q != 4'd8) begin
          if (rd_q) sh_d = {sh_q[6:0], sda_in};
          else      lost = !wbit && !sda_in;
        end
        if (samp && bit_q == 4'd8 && !rd_q)
          rxack_d = sda_in;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
        if (rd_q) rx_d = sh_q;
      end
      default: state_d = IDLE;
    endcase

    if (run) begin
      sclh_d = scl_oe;
      sdah_d = sda_oe;
      if (ph_end)     cnt_d = '0;
      else if (!stall) cnt_d = cnt_q + CNT_BITS'(1);
      if (ph_end) begin
        ph_d = ph_q + 2'd1;
        if (ph_q == 2'd3) begin
          if (state_q == BIT && bit_q != 4'd8) begin
            bit_d = bit_q + 4'd1;
            tx_d  = {tx_q[6:0], 1'b0};
          end else begin
            state_d = DONE;
          end
        end
      end
      if (lost) begin
        state_d = IDLE;
        done_d  = 1'b1;
        arb_d   = 1'b1;
        sclh_d  = 1'b0;
        sdah_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      ph_q    <= '0;
      cnt_q   <= '0;
      bit_q   <= '0;
      rd_q    <= 1'b0;
      ack_q   <= 1'b0;
      tx_q    <= '0;
      sh_q    <= '0;
      rx_q    <= '0;
      rxack_q <= 1'b0;
      done_q  <= 1'b0;
      arb_q   <= 1'b0;
      sclh_q  <= 1'b0;
      sdah_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rd_q    <= rd_d;
      ack_q   <= ack_d;
      tx_q    <= tx_d;
      sh_q    <= sh_d;
      rx_q    <= rx_d;
      rxack_q <= rxack_d;
      done_q  <= done_d;
      arb_q   <= arb_d;
      sclh_q  <= sclh_d;
      sdah_q  <= sdah_d;
    end
  end

  assign cmd_ready = state_q == IDLE && !done_q;
  assign rx_data   = rx_q;
  assign rx_ack    = rxack_q;
  assign done      = done_q;
  assign arb_lost  = arb_q;

endmodule
